sram_bus_adaptor_4096_x_32: RTL and testbench

Bus-side front end for the 4096 x 32 byte-laned single-port SRAM macro (memory_s_sp_4096_x_4b8).
- Accepts byte, halfword and word requests from an internal master over a request/ack handshake.
- Generates the SRAM strobes, word address, byte enables and lane-replicated write data.
- Extracts, extends and registers the read result.
- Detects misaligned accesses and completes them with an error, without touching the SRAM.

---
 rtl/sram_bus_adaptor_4096_x_32.sv | 165 ++++++++++++++++
 tb/tb_sram_bus_adaptor_4096_x_32.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_adaptor_4096_x_32.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_adaptor_4096_x_32
// Purpose  : Bus-side front end for the 4096 x 32 byte-laned single-port SRAM.
//            Turns byte/half/word requests into SRAM strobes, byte enables and
//            lane-replicated write data. Extracts and extends read results.
//            Misaligned or illegal-size requests complete with an error and
//            never reach the SRAM.
// Ports    : int_clock, int_reset (sync, active-low)
//            bus_request/bus_write/bus_size/bus_signed/bus_address/
//            bus_write_data    -> request side from the master
//            bus_ack/bus_error/bus_read_data -> completion back to the master
//            sram_read/sram_write/sram_byte_enables/sram_address/
//            sram_write_data   -> SRAM macro controls
//            sram_read_data    -> SRAM output, valid the cycle after sram_read
// Revision : 1.0 - initial release
// ============================================================================
module sram_bus_adaptor_4096_x_32 (
  input  logic        int_clock,
  input  logic        int_reset,
  input  logic        bus_request,
  input  logic        bus_write,
  input  logic [1:0]  bus_size,
  input  logic        bus_signed,
  input  logic [13:0] bus_address,
  input  logic [31:0] bus_write_data,
  output logic        bus_ack,
  output logic        bus_error,
  output logic [31:0] bus_read_data,
  output logic        sram_read,
  output logic        sram_write,
  output logic [3:0]  sram_byte_enables,
  output logic [11:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic [31:0] sram_read_data
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCESS    = 2'd1,
    READ_WAIT = 2'd2,
    ACK       = 2'd3
  } state_t;

  state_t      r_state;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_lane;

  logic        w_misaligned;
  logic [3:0]  w_byte_enables;
  logic [31:0] w_write_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_read_result;

  // Request decode: alignment check, lane enables and replicated write data.
  always_comb begin
    w_misaligned   = 1'b0;
    w_byte_enables = 4'b1111;
    w_write_data   = bus_write_data;
    case (bus_size)
      2'b00: begin
        w_byte_enables = 4'b0001 << bus_address[1:0];
        w_write_data   = {4{bus_write_data[7:0]}};
      end
      2'b01: begin
        w_misaligned   = bus_address[0];
        w_byte_enables = bus_address[1] ? 4'b1100 : 4'b0011;
        w_write_data   = {2{bus_write_data[15:0]}};
      end
      2'b10: begin
        w_misaligned   = |bus_address[1:0];
      end
      default: begin
        w_misaligned   = 1'b1;
      end
    endcase
  end

  // Read extraction uses the lane/size captured at acceptance, so the
  // result does not depend on the master's inputs after the SRAM cycle.
  always_comb begin
    w_byte = sram_read_data[7:0];
    case (r_lane)
      2'd0:    w_byte = sram_read_data[7:0];
      2'd1:    w_byte = sram_read_data[15:8];
      2'd2:    w_byte = sram_read_data[23:16];
      default: w_byte = sram_read_data[31:24];
    endcase
    w_half = r_lane[1] ? sram_read_data[31:16] : sram_read_data[15:0];
    case (r_size)
      2'b00:   w_read_result = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_read_result = {{16{r_signed & w_half[15]}}, w_half};
      default: w_read_result = sram_read_data;
    endcase
  end

  always_ff @(posedge int_clock) begin
    if (!int_reset) begin
      r_state           <= IDLE;
      r_size            <= 2'b00;
      r_signed          <= 1'b0;
      r_lane            <= 2'b00;
      bus_ack           <= 1'b0;
      bus_error         <= 1'b0;
      bus_read_data     <= 32'h0;
      sram_read         <= 1'b0;
      sram_write        <= 1'b0;
      sram_byte_enables <= 4'h0;
      sram_address      <= 12'h0;
      sram_write_data   <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          bus_ack   <= 1'b0;
          bus_error <= 1'b0;
          if (bus_request) begin
            if (w_misaligned) begin
              // Complete immediately with an error; SRAM is left untouched.
              bus_ack       <= 1'b1;
              bus_error     <= 1'b1;
              bus_read_data <= 32'h0;
              r_state       <= ACK;
            end else begin
              sram_read         <= ~bus_write;
              sram_write        <= bus_write;
              // Writes are acknowledged in the same cycle as the strobe.
              bus_ack           <= bus_write;
              sram_address      <= bus_address[13:2];
              sram_byte_enables <= w_byte_enables;
              sram_write_data   <= w_write_data;
              r_size            <= bus_size;
              r_signed          <= bus_signed;
              r_lane            <= bus_address[1:0];
              r_state           <= ACCESS;
            end
          end
        end
        ACCESS: begin
          sram_read  <= 1'b0;
          sram_write <= 1'b0;
          bus_ack    <= 1'b0;
          r_state    <= sram_write ? IDLE : READ_WAIT;
        end
        READ_WAIT: begin
          bus_read_data <= w_read_result;
          bus_ack       <= 1'b1;
          bus_error     <= 1'b0;
          r_state       <= ACK;
        end
        ACK: begin
          bus_ack   <= 1'b0;
          bus_error <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_adaptor_4096_x_32.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_bus_adaptor_4096_x_32
// Purpose  : Self-checking bench for sram_bus_adaptor_4096_x_32. A driver
//            issues directed and random accesses and pushes the expected
//            SRAM strobe and completion into queues; monitors pop and compare
//            whenever the DUT strobes the SRAM or acknowledges. Expected
//            values come from a byte-addressed memory model.
// Ports    : none (top-level bench)
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bus_adaptor_4096_x_32;

  logic        int_clock = 1'b0;
  logic        int_reset = 1'b0;
  logic        bus_request = 1'b0;
  logic        bus_write = 1'b0;
  logic [1:0]  bus_size = 2'b00;
  logic        bus_signed = 1'b0;
  logic [13:0] bus_address = 14'h0;
  logic [31:0] bus_write_data = 32'h0;
  logic        bus_ack;
  logic        bus_error;
  logic [31:0] bus_read_data;
  logic        sram_read;
  logic        sram_write;
  logic [3:0]  sram_byte_enables;
  logic [11:0] sram_address;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data;

  sram_bus_adaptor_4096_x_32 dut (
    .int_clock         (int_clock),
    .int_reset         (int_reset),
    .bus_request       (bus_request),
    .bus_write         (bus_write),
    .bus_size          (bus_size),
    .bus_signed        (bus_signed),
    .bus_address       (bus_address),
    .bus_write_data    (bus_write_data),
    .bus_ack           (bus_ack),
    .bus_error         (bus_error),
    .bus_read_data     (bus_read_data),
    .sram_read         (sram_read),
    .sram_write        (sram_write),
    .sram_byte_enables (sram_byte_enables),
    .sram_address      (sram_address),
    .sram_write_data   (sram_write_data),
    .sram_read_data    (sram_read_data)
  );

  always #5 int_clock = ~int_clock;

  int cyc = 0;
  always @(posedge int_clock) cyc <= cyc + 1;

  // Stand-in for the SRAM macro: byte-laned write, one-cycle read latency.
  logic [31:0] sram_mem [0:4095];
  logic [31:0] sram_q = 32'h0;
  assign sram_read_data = sram_q;
  always @(posedge int_clock) begin
    if (sram_write)
      for (int k = 0; k < 4; k++)
        if (sram_byte_enables[k]) sram_mem[sram_address][8*k +: 8] <= sram_write_data[8*k +: 8];
    if (sram_read) sram_q <= sram_mem[sram_address];
  end

  typedef struct {
    int          cyc;
    logic        err;
    logic        chk_data;
    logic [31:0] data;
  } ack_exp_t;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } strb_exp_t;

  ack_exp_t  ack_q[$];
  strb_exp_t strb_q[$];
  logic [7:0] ref_mem [0:16383];
  int total = 0;
  int bad = 0;
  int last_ack = -100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Completion monitor.
  always @(negedge int_clock) begin
    ack_exp_t ae;
    if (bus_ack) begin
      if (ack_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
      end else begin
        ae = ack_q.pop_front();
        check("ack_cycle", 32'(cyc), 32'(ae.cyc));
        check("ack_error", 32'(bus_error), 32'(ae.err));
        if (ae.chk_data) check("read_data", bus_read_data, ae.data);
      end
    end
  end

  // SRAM strobe monitor.
  always @(negedge int_clock) begin
    strb_exp_t se;
    if (sram_read || sram_write) begin
      check("strobe_one_hot", 32'(sram_read & sram_write), 32'h0);
      if (strb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc);
      end else begin
        se = strb_q.pop_front();
        check("strobe_cycle", 32'(cyc), 32'(se.cyc));
        check("strobe_kind", 32'(sram_write), 32'(se.wr));
        check("sram_address", 32'(sram_address), 32'(se.addr));
        check("byte_enables", 32'(sram_byte_enables), 32'(se.be));
        if (se.wr) check("sram_write_data", sram_write_data, se.wd);
      end
    end
  end

  // Drive a request and record what the adaptor must do with it.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [13:0] a, input logic [31:0] d);
    int accept, nb, lane, ai;
    logic [31:0] v;
    ack_exp_t ae;
    strb_exp_t se;
    bus_request    = 1'b1;
    bus_write      = w;
    bus_size       = sz;
    bus_signed     = sg;
    bus_address    = a;
    bus_write_data = d;
    // The adaptor samples at the next edge, but never earlier than two
    // edges after the previous acknowledge became visible.
    accept = (cyc + 1 > last_ack + 2) ? cyc + 1 : last_ack + 2;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    ai   = int'(a);
    lane = ai % 4;
    ae.cyc = accept; ae.err = 1'b0; ae.chk_data = 1'b0; ae.data = 32'h0;
    if (sz == 2'd3 || (ai % nb) != 0) begin
      ae.err = 1'b1;
      ae.chk_data = 1'b1;
    end else begin
      se.cyc  = accept;
      se.wr   = w;
      se.addr = a[13:2];
      se.be   = 4'h0;
      se.wd   = 32'h0;
      for (int k = 0; k < 4; k++) begin
        if (k >= lane && k < lane + nb) se.be[k] = 1'b1;
        se.wd[8*k +: 8] = d[8*(k % nb) +: 8];
      end
      if (w) begin
        for (int i = 0; i < nb; i++) ref_mem[ai + i] = d[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[ai + i];
        if (sg && nb < 4 && v[8*nb-1])
          for (int b = 8*nb; b < 32; b++) v[b] = 1'b1;
        ae.cyc = accept + 2;
        ae.chk_data = 1'b1;
        ae.data = v;
      end
      strb_q.push_back(se);
    end
    ack_q.push_back(ae);
  endtask

  task automatic wait_ack();
    bit got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge int_clock);
      got = bus_ack;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL ack_timeout: got no ack by cycle %0d expected one within 40 cycles", cyc);
    end else begin
      last_ack = cyc;
    end
  endtask

  task automatic xact(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [13:0] a, input logic [31:0] d, input int gap);
    issue(w, sz, sg, a, d);
    wait_ack();
    if (gap > 0) begin
      bus_request = 1'b0;
      repeat (gap) @(negedge int_clock);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by time %0t expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [13:0] ra;
    logic [1:0]  rs;
    int          r;
    for (int i = 0; i < 16384; i++) ref_mem[i] = 8'h00;

    // Reset held with a pending request: nothing may happen.
    bus_request = 1'b1; bus_write = 1'b1; bus_size = 2'd2;
    bus_address = 14'h0104; bus_write_data = 32'hDEADBEEF;
    repeat (3) begin
      @(negedge int_clock);
      check("reset_ctrl", 32'({bus_ack, bus_error, sram_read, sram_write, sram_byte_enables}), 32'h0);
      check("reset_addr", 32'(sram_address), 32'h0);
      check("reset_wdata", sram_write_data, 32'h0);
      check("reset_rdata", bus_read_data, 32'h0);
    end
    int_reset = 1'b1;
    xact(1'b1, 2'd2, 1'b0, 14'h0104, 32'hDEADBEEF, 2);

    // Give every word in the test windows a known value.
    for (int w = 0; w < 16; w++) begin
      if (w != 1) xact(1'b1, 2'd2, 1'b0, 14'h0100 + 14'(w*4), 32'h0, 0);
      xact(1'b1, 2'd2, 1'b0, 14'h3FC0 + 14'(w*4), 32'h0, 0);
    end
    bus_request = 1'b0;
    repeat (2) @(negedge int_clock);

    // Directed cases.
    xact(1'b0, 2'd2, 1'b0, 14'h0104, 32'h0, 1);          // word read DEADBEEF
    xact(1'b1, 2'd0, 1'b0, 14'h0107, 32'h0000005A, 1);   // byte write, lane 3
    xact(1'b1, 2'd0, 1'b0, 14'h0107, 32'h00000080, 1);
    xact(1'b0, 2'd0, 1'b1, 14'h0107, 32'h0, 1);          // signed byte
    xact(1'b0, 2'd0, 1'b0, 14'h0107, 32'h0, 1);          // unsigned byte
    xact(1'b1, 2'd2, 1'b0, 14'h0104, 32'h80011234, 1);
    xact(1'b0, 2'd1, 1'b0, 14'h0106, 32'h0, 1);          // unsigned half
    xact(1'b0, 2'd1, 1'b1, 14'h0106, 32'h0, 1);          // signed half
    xact(1'b0, 2'd2, 1'b0, 14'h0102, 32'h0, 1);          // misaligned word
    xact(1'b0, 2'd3, 1'b0, 14'h0100, 32'h0, 1);          // illegal size
    xact(1'b1, 2'd2, 1'b0, 14'h3FFC, 32'hCAFEF00D, 0);   // word 4095
    xact(1'b0, 2'd2, 1'b0, 14'h3FFC, 32'h0, 1);

    // Back-to-back with request held: W, W, R, R.
    xact(1'b1, 2'd2, 1'b0, 14'h0110, 32'h11223344, 0);
    xact(1'b1, 2'd1, 1'b0, 14'h0116, 32'h0000A5C3, 0);
    xact(1'b0, 2'd2, 1'b0, 14'h0110, 32'h0, 0);
    xact(1'b0, 2'd1, 1'b1, 14'h0116, 32'h0, 2);

    // Reset during READ_WAIT: the access must be abandoned without ack.
    issue(1'b0, 2'd2, 1'b0, 14'h0110, 32'h0);
    void'(ack_q.pop_back());
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge int_clock);
      seen = sram_read;
    end
    check("midrst_read_strobe", 32'(seen), 32'h1);
    @(negedge int_clock);
    int_reset = 1'b0;
    bus_request = 1'b0;
    @(negedge int_clock);
    check("midrst_ctrl", 32'({bus_ack, bus_error, sram_read, sram_write, sram_byte_enables}), 32'h0);
    check("midrst_rdata", bus_read_data, 32'h0);
    int_reset = 1'b1;
    last_ack = -100;
    repeat (5) @(negedge int_clock);
    xact(1'b1, 2'd0, 1'b0, 14'h0111, 32'h000000EE, 1);   // idle: accepted next edge

    // Randomized traffic within the preloaded windows.
    for (int t = 0; t < 300; t++) begin
      ra = ($urandom_range(0, 7) == 0) ? 14'h3FC0 + 14'($urandom_range(0, 63))
                                       : 14'h0100 + 14'($urandom_range(0, 63));
      r  = int'($urandom_range(0, 9));
      rs = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      xact(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom(),
           int'($urandom_range(0, 2)));
    end

    bus_request = 1'b0;
    repeat (8) @(negedge int_clock);
    check("ack_queue_drained", 32'(ack_q.size()), 32'h0);
    check("strobe_queue_drained", 32'(strb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
